// File: rtl/ga_generation_scheduler.sv
// Generation sequencer for one GA run: fitness -> check -> selection -> mutation -> commit,
// with best-cost tracking, stagnation/generation-limit stop, per-stage timeout and abort.
module ga_generation_scheduler #(
    parameter int unsigned NUM_GENERATIONS = 100,
    parameter int unsigned STALL_LIMIT     = 20,
    parameter logic [15:0] STAGE_TIMEOUT   = 16'd50000,
    parameter logic [31:0] SEED_INIT       = 32'hACE1_2015
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        abort,
    output logic        fit_start,
    input  logic        fit_done,
    input  logic [15:0] fit_best_cost,
    output logic        sel_start,
    input  logic        sel_done,
    output logic        mut_start,
    input  logic        mut_done,
    output logic [31:0] prg_seed,
    output logic        pop_load,
    output logic [15:0] generation,
    output logic [15:0] best_cost,
    output logic [15:0] best_gen,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [3:0]  state_dbg
);
    // Stage handshake: *_start is a one-cycle pulse; the stage answers later with *_done.
    // Only the first high cycle of *_done in the matching *_W state is taken; done seen
    // while in *_S or any other state is ignored.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FIT_S  = 4'd1,
        FIT_W  = 4'd2,
        CHECK  = 4'd3,
        SEL_S  = 4'd4,
        SEL_W  = 4'd5,
        MUT_S  = 4'd6,
        MUT_W  = 4'd7,
        COMMIT = 4'd8,
        DONE   = 4'd9,
        ERR    = 4'd10
    } state_t;

    localparam logic [15:0] NUM_GEN_C = 16'(NUM_GENERATIONS);
    localparam logic [15:0] STALL_C   = 16'(STALL_LIMIT);
    localparam logic [31:0] SEED_RUN  = (SEED_INIT == 32'd0) ? 32'd1 : SEED_INIT;

    state_t      state_q, state_d;
    logic [15:0] gen_q, gen_d;
    logic [15:0] best_q, best_d;
    logic [15:0] best_gen_q, best_gen_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] seed_q, seed_d;
    logic        terr_q, terr_d;
    logic        tmo_hit;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // tmo_q counts completed wait cycles, so this fires on the STAGE_TIMEOUT-th cycle.
    assign tmo_hit = ({1'b0, tmo_q} + 17'd1) >= {1'b0, STAGE_TIMEOUT};

    always_comb begin
        state_d    = state_q;
        gen_d      = gen_q;
        best_d     = best_q;
        best_gen_d = best_gen_q;
        stall_d    = stall_q;
        seed_d     = seed_q;
        terr_d     = terr_q;
        tmo_d      = '0;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = FIT_S;
                        gen_d   = '0;
                        best_d  = 16'hFFFF;
                        stall_d = '0;
                        seed_d  = SEED_RUN;
                        terr_d  = 1'b0;
                    end
                end
                FIT_S: state_d = FIT_W;
                FIT_W: begin
                    if (fit_done) begin
                        state_d = CHECK;
                        if (fit_best_cost < best_q) begin
                            best_d     = fit_best_cost;
                            best_gen_d = gen_q;
                            stall_d    = '0;
                        end else if (stall_q != 16'hFFFF) begin
                            stall_d = stall_q + 16'd1;
                        end
                    end else if (tmo_hit) begin
                        state_d = ERR;
                        terr_d  = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
                CHECK: begin
                    if ((gen_q == NUM_GEN_C) || ((STALL_LIMIT != 0) && (stall_q >= STALL_C)))
                        state_d = DONE;
                    else
                        state_d = SEL_S;
                end
                SEL_S: state_d = SEL_W;
                SEL_W: begin
                    if (sel_done) begin
                        state_d = MUT_S;
                    end else if (tmo_hit) begin
                        state_d = ERR;
                        terr_d  = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
                MUT_S: state_d = MUT_W;
                MUT_W: begin
                    if (mut_done) begin
                        state_d = COMMIT;
                    end else if (tmo_hit) begin
                        state_d = ERR;
                        terr_d  = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
                COMMIT: begin
                    state_d = FIT_S;
                    gen_d   = gen_q + 16'd1;
                    seed_d  = lfsr_next(seed_q);
                end
                DONE:    state_d = IDLE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gen_q      <= '0;
            best_q     <= 16'hFFFF;
            best_gen_q <= '0;
            stall_q    <= '0;
            tmo_q      <= '0;
            seed_q     <= SEED_INIT;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gen_q      <= gen_d;
            best_q     <= best_d;
            best_gen_q <= best_gen_d;
            stall_q    <= stall_d;
            tmo_q      <= tmo_d;
            seed_q     <= seed_d;
            terr_q     <= terr_d;
        end
    end

    assign fit_start   = (state_q == FIT_S);
    assign sel_start   = (state_q == SEL_S);
    assign mut_start   = (state_q == MUT_S);
    assign pop_load    = (state_q == COMMIT);
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign prg_seed    = seed_q;
    assign generation  = gen_q;
    assign best_cost   = best_q;
    assign best_gen    = best_gen_q;
    assign timeout_err = terr_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_ga_generation_scheduler.sv
// Directed bench: instance 0 (2 generations, no stall stop, timeout 10, seed 1),
// instance 1 (100 generations, stall limit 2, default timeout and seed).
module tb_ga_generation_scheduler;
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_SEL_W = 4'd5;
    localparam logic [3:0] S_ERR   = 4'd10;

    logic        clk;
    logic        reset;
    logic        run_v       [2];
    logic        abort_v     [2];
    logic        fit_done_v  [2];
    logic        sel_done_v  [2];
    logic        mut_done_v  [2];
    logic [15:0] fit_cost_v  [2];
    logic        fit_start_v [2];
    logic        sel_start_v [2];
    logic        mut_start_v [2];
    logic [31:0] prg_seed_v  [2];
    logic        pop_load_v  [2];
    logic [15:0] generation_v[2];
    logic [15:0] best_cost_v [2];
    logic [15:0] best_gen_v  [2];
    logic        busy_v      [2];
    logic        done_v      [2];
    logic        terr_v      [2];
    logic [3:0]  state_v     [2];

    int checks   = 0;
    int failures = 0;
    int fit_cnt [2];
    int sel_cnt [2];
    int mut_cnt [2];
    int pop_cnt [2];
    int done_cnt[2];
    logic clr_cnt;
    logic [31:0] exp_q[$];

    ga_generation_scheduler #(
        .NUM_GENERATIONS(2), .STALL_LIMIT(0), .STAGE_TIMEOUT(16'd10), .SEED_INIT(32'h0000_0001)
    ) u_dut0 (
        .clk(clk), .reset(reset), .run(run_v[0]), .abort(abort_v[0]),
        .fit_start(fit_start_v[0]), .fit_done(fit_done_v[0]), .fit_best_cost(fit_cost_v[0]),
        .sel_start(sel_start_v[0]), .sel_done(sel_done_v[0]),
        .mut_start(mut_start_v[0]), .mut_done(mut_done_v[0]),
        .prg_seed(prg_seed_v[0]), .pop_load(pop_load_v[0]), .generation(generation_v[0]),
        .best_cost(best_cost_v[0]), .best_gen(best_gen_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .timeout_err(terr_v[0]), .state_dbg(state_v[0])
    );

    ga_generation_scheduler #(
        .NUM_GENERATIONS(100), .STALL_LIMIT(2)
    ) u_dut1 (
        .clk(clk), .reset(reset), .run(run_v[1]), .abort(abort_v[1]),
        .fit_start(fit_start_v[1]), .fit_done(fit_done_v[1]), .fit_best_cost(fit_cost_v[1]),
        .sel_start(sel_start_v[1]), .sel_done(sel_done_v[1]),
        .mut_start(mut_start_v[1]), .mut_done(mut_done_v[1]),
        .prg_seed(prg_seed_v[1]), .pop_load(pop_load_v[1]), .generation(generation_v[1]),
        .best_cost(best_cost_v[1]), .best_gen(best_gen_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .timeout_err(terr_v[1]), .state_dbg(state_v[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr_cnt) begin
                fit_cnt[i] = 0; sel_cnt[i] = 0; mut_cnt[i] = 0; pop_cnt[i] = 0; done_cnt[i] = 0;
            end else begin
                fit_cnt[i]  += int'(fit_start_v[i]);
                sel_cnt[i]  += int'(sel_start_v[i]);
                mut_cnt[i]  += int'(mut_start_v[i]);
                pop_cnt[i]  += int'(pop_load_v[i]);
                done_cnt[i] += int'(done_v[i]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic start_of(input int d, input int w);
        case (w)
            0:       return fit_start_v[d];
            1:       return sel_start_v[d];
            default: return mut_start_v[d];
        endcase
    endfunction

    task automatic set_done(input int d, input int w, input logic v);
        case (w)
            0:       fit_done_v[d] = v;
            1:       sel_done_v[d] = v;
            default: mut_done_v[d] = v;
        endcase
    endtask

    task automatic wait_start(input int d, input int w, output bit ok);
        int n = 0;
        while (!start_of(d, w) && n < 100) begin
            tick();
            n++;
        end
        ok = start_of(d, w);
        check($sformatf("start_seen_%0d_%0d", d, w), {31'b0, ok}, 32'd1);
    endtask

    // stage model: answers done on the third wait cycle
    task automatic do_stage(input int d, input int w, input logic [15:0] cost);
        bit ok;
        wait_start(d, w, ok);
        if (!ok) return;
        if (w == 1 && d == 0 && exp_q.size() > 0)
            check("seed_at_sel", prg_seed_v[0], exp_q.pop_front());
        repeat (3) tick();
        fit_cost_v[d] = cost;
        set_done(d, w, 1'b1);
        tick();
        set_done(d, w, 1'b0);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done_v[d] && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("done_seen_%0d", d), {31'b0, done_v[d]}, 32'd1);
    endtask

    task automatic start_run(input int d);
        run_v[d] = 1'b1;
        tick();
        run_v[d] = 1'b0;
    endtask

    initial begin
        bit ok;
        reset   = 1'b1;
        clr_cnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_v[i] = 0; abort_v[i] = 0; fit_done_v[i] = 0; sel_done_v[i] = 0;
            mut_done_v[i] = 0; fit_cost_v[i] = 16'd0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset values
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", {31'b0, busy_v[i]}, 32'd0);
            check("rst_best_cost", {16'b0, best_cost_v[i]}, 32'h0000_FFFF);
            check("rst_generation", {16'b0, generation_v[i]}, 32'd0);
            check("rst_terr", {31'b0, terr_v[i]}, 32'd0);
            check("rst_outs", {27'b0, fit_start_v[i], sel_start_v[i], mut_start_v[i],
                               pop_load_v[i], done_v[i]}, 32'd0);
            check("rst_best_gen", {16'b0, best_gen_v[i]}, 32'd0);
            check("rst_state", {28'b0, state_v[i]}, {28'b0, S_IDLE});
        end
        check("rst_seed0", prg_seed_v[0], 32'h0000_0001);
        check("rst_seed1", prg_seed_v[1], 32'hACE1_2015);
        clr_cnt = 1'b0;

        // two full generations, improving costs, LFSR sequence
        start_run(0);
        check("t1_fit_start_latency", {31'b0, fit_start_v[0]}, 32'd1);
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h8020_0003);
        do_stage(0, 0, 16'd500);
        do_stage(0, 1, 16'd0);
        do_stage(0, 2, 16'd0);
        do_stage(0, 0, 16'd400);
        do_stage(0, 1, 16'd0);
        do_stage(0, 2, 16'd0);
        do_stage(0, 0, 16'd300);
        wait_done(0);
        repeat (3) tick();
        check("t1_generation", {16'b0, generation_v[0]}, 32'd2);
        check("t1_best_cost", {16'b0, best_cost_v[0]}, 32'd300);
        check("t1_best_gen", {16'b0, best_gen_v[0]}, 32'd2);
        check("t1_pop_loads", pop_cnt[0], 32'd2);
        check("t1_fit_starts", fit_cnt[0], 32'd3);
        check("t1_done_pulses", done_cnt[0], 32'd1);
        check("t1_seed_final", prg_seed_v[0], 32'hC030_0002);
        check("t1_busy", {31'b0, busy_v[0]}, 32'd0);
        check("t1_seed_q_empty", exp_q.size(), 32'd0);

        // stagnation stop on ties
        start_run(1);
        check("t2_seed_run", prg_seed_v[1], 32'hACE1_2015);
        for (int g = 0; g < 3; g++) begin
            do_stage(1, 0, 16'd700);
            if (g < 2) begin
                do_stage(1, 1, 16'd0);
                do_stage(1, 2, 16'd0);
            end
        end
        wait_done(1);
        repeat (2) tick();
        check("t2_generation", {16'b0, generation_v[1]}, 32'd2);
        check("t2_best_cost", {16'b0, best_cost_v[1]}, 32'd700);
        check("t2_best_gen", {16'b0, best_gen_v[1]}, 32'd0);
        check("t2_pop_loads", pop_cnt[1], 32'd2);
        check("t2_done_pulses", done_cnt[1], 32'd1);

        // selection never answers -> timeout
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        start_run(0);
        do_stage(0, 0, 16'd100);
        wait_start(0, 1, ok);
        repeat (10) tick();
        check("t3_still_waiting", {28'b0, state_v[0]}, {28'b0, S_SEL_W});
        check("t3_terr_early", {31'b0, terr_v[0]}, 32'd0);
        tick();
        check("t3_state_err", {28'b0, state_v[0]}, {28'b0, S_ERR});
        check("t3_terr", {31'b0, terr_v[0]}, 32'd1);
        repeat (3) tick();
        check("t3_err_busy", {31'b0, busy_v[0]}, 32'd1);
        check("t3_no_mut_start", mut_cnt[0], 32'd0);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("t3_abort_idle", {31'b0, busy_v[0]}, 32'd0);
        check("t3_terr_sticky", {31'b0, terr_v[0]}, 32'd1);
        start_run(0);
        check("t3_terr_cleared", {31'b0, terr_v[0]}, 32'd0);
        check("t3_fit_start", {31'b0, fit_start_v[0]}, 32'd1);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;

        // abort while waiting on mutation
        start_run(0);
        do_stage(0, 0, 16'd200);
        do_stage(0, 1, 16'd0);
        do_stage(0, 2, 16'd0);
        do_stage(0, 0, 16'd150);
        do_stage(0, 1, 16'd0);
        wait_start(0, 2, ok);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("t4_state_idle", {28'b0, state_v[0]}, {28'b0, S_IDLE});
        check("t4_busy", {31'b0, busy_v[0]}, 32'd0);
        check("t4_generation", {16'b0, generation_v[0]}, 32'd1);
        check("t4_best_cost", {16'b0, best_cost_v[0]}, 32'd150);
        check("t4_best_gen", {16'b0, best_gen_v[0]}, 32'd1);
        repeat (3) tick();
        check("t4_no_pop_load", pop_cnt[0], 32'd0);
        check("t4_no_done", done_cnt[0], 32'd0);

        // abort in IDLE is ignored; run beats abort
        abort_v[0] = 1'b1;
        tick();
        check("t5_idle_abort", {28'b0, state_v[0]}, {28'b0, S_IDLE});
        run_v[0] = 1'b1;
        tick();
        run_v[0]   = 1'b0;
        abort_v[0] = 1'b0;
        check("t5_run_wins", {31'b0, fit_start_v[0]}, 32'd1);

        // reset during FIT_W with fit_done high
        tick();
        fit_done_v[0] = 1'b1;
        fit_cost_v[0] = 16'd50;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fit_done_v[0] = 1'b0;
        check("t6_state", {28'b0, state_v[0]}, {28'b0, S_IDLE});
        check("t6_best_cost", {16'b0, best_cost_v[0]}, 32'h0000_FFFF);
        check("t6_busy", {31'b0, busy_v[0]}, 32'd0);
        check("t6_seed", prg_seed_v[0], 32'h0000_0001);
        tick();
        check("t6_stays_idle", {28'b0, state_v[0]}, {28'b0, S_IDLE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
